// File: rtl/snn_pkg.sv
// Shared types and default widths for the SNN timestep sequencer.
// State encoding is fixed at 3 bits so it can be probed externally.
package snn_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_STEP,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

endpackage

// File: rtl/snn_timestep_sequencer_if.sv
// Input-current stream: one word per timestep, valid/ready handshake.
// The sequencer is the slave; the Wishbone/I-O side is the master.
interface snn_timestep_sequencer_if
  import snn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/snn_spike_counter.sv
// Saturating per-neuron spike counters with argmax (ties -> lowest index).
// best is taken over the next-cycle counts so it already includes this sample.
module snn_spike_counter #(
  parameter int N     = 2,
  parameter int CNT_W = 8,
  parameter int WIN_W = 1
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               clr,
  input  logic [N-1:0]       inc,
  output logic [N*CNT_W-1:0] cnt,
  output logic [WIN_W-1:0]   best
);

  logic [CNT_W-1:0] q   [N];
  logic [CNT_W-1:0] nxt [N];
  logic [CNT_W-1:0] top;

  always_comb begin
    best = '0;
    top  = '0;
    for (int i = 0; i < N; i++) begin
      nxt[i] = q[i];
      if (clr)
        nxt[i] = '0;
      else if (inc[i] && (q[i] != '1))
        nxt[i] = q[i] + 1'b1;
      // strict compare keeps the lowest index on ties
      if (nxt[i] > top) begin
        top  = nxt[i];
        best = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int i = 0; i < N; i++)
        q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        q[i] <= nxt[i];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign cnt[g*CNT_W +: CNT_W] = q[g];
  end

endmodule

// File: rtl/snn_timestep_sequencer.sv
// Timestep sequencer for the LIF neuron array: clear, then per step
// take one current word, pulse neuron_en, settle, and count spikes.
module snn_timestep_sequencer
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STEP_W     = DEF_STEP_W,
  parameter int SETTLE_CYC = 2,
  localparam int WIN_W =
    (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       start,
  input  logic [STEP_W-1:0]          num_steps,
  snn_timestep_sequencer_if.slave    src,
  output logic [DATA_W-1:0]          neuron_in,
  output logic                       neuron_en,
  output logic                       neuron_rst,
  input  logic [N_NEURONS-1:0]       spike_in,
  output logic                       busy,
  output logic                       done,
  output logic [STEP_W-1:0]          step_idx,
  output logic [N_NEURONS*CNT_W-1:0] spike_cnt,
  output logic [WIN_W-1:0]           winner
);

  localparam int TMR_W =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(SETTLE_CYC - 1);

  state_t               state;
  logic [STEP_W-1:0]    steps;
  logic [TMR_W-1:0]     tmr;
  logic                 rdy;
  logic [WIN_W-1:0]     best;
  logic                 clr;
  logic [N_NEURONS-1:0] inc;

  assign src.in_ready = rdy;
  assign clr = (state == S_CLEAR);
  assign inc = (state == S_SAMPLE) ? spike_in : '0;

  snn_spike_counter #(
    .N     (N_NEURONS),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) u_cnt (
    .clk    (clk),
    .resetb (resetb),
    .clr    (clr),
    .inc    (inc),
    .cnt    (spike_cnt),
    .best   (best)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= S_IDLE;
      steps      <= '0;
      tmr        <= '0;
      rdy        <= 1'b0;
      neuron_in  <= '0;
      neuron_en  <= 1'b0;
      neuron_rst <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_idx   <= '0;
      winner     <= '0;
    end else begin
      neuron_en  <= 1'b0;
      neuron_rst <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            steps      <= num_steps;
            neuron_rst <= 1'b1;
            busy       <= 1'b1;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          step_idx <= '0;
          winner   <= '0;
          if (steps == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            rdy   <= 1'b1;
            state <= S_WAIT_IN;
          end
        end
        S_WAIT_IN: begin
          if (src.in_valid) begin
            neuron_in <= src.in_data;
            rdy       <= 1'b0;
            neuron_en <= 1'b1;
            state     <= S_STEP;
          end
        end
        S_STEP: begin
          tmr <= '0;
          if (SETTLE_CYC == 0)
            state <= S_SAMPLE;
          else
            state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (tmr == TMR_LAST)
            state <= S_SAMPLE;
          else
            tmr <= tmr + 1'b1;
        end
        S_SAMPLE: begin
          if (step_idx == steps - 1'b1) begin
            done   <= 1'b1;
            winner <= best;
            state  <= S_DONE;
          end else begin
            step_idx <= step_idx + 1'b1;
            rdy      <= 1'b1;
            state    <= S_WAIT_IN;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
